l2_arbiter: RTL and testbench
=============================

// Module: l2_arbiter
//
// PURPOSE
// Shares the single unified L2 cache port between the L1 I-cache and L1 D-cache miss paths.
// Two-requester round-robin arbiter with a grant-holding FSM.
// Latches the winner's request and drives it to L2 until l2_resp, then returns the response to that requester only.
// Sits between the two L1 controllers and the L2 control/datapath.
//
// PARAMETERS
// ADDR_W  32   address width (line-aligned address; low 5 bits passed through unchanged)
// LINE_W  256  cache line width in bits
// CNT_W   16   width of the saturating per-requester grant counters
//
// PORTS
// clk       in   1       clock
// rst       in   1       synchronous active-high reset
// i_read    in   1       I-cache line read request; held until i_resp
// i_addr    in   ADDR_W  I-cache request address
// i_rdata   out  LINE_W  line returned to I-cache
// i_resp    out  1       one-cycle completion pulse to I-cache
// d_read    in   1       D-cache line read request; held until d_resp
// d_write   in   1       D-cache line write-back request; held until d_resp
// d_addr    in   ADDR_W  D-cache request address
// d_wdata   in   LINE_W  D-cache write-back line
// d_rdata   out  LINE_W  line returned to D-cache
// d_resp    out  1       one-cycle completion pulse to D-cache
// l2_read   out  1       read request to L2
// l2_write  out  1       write request to L2
// l2_addr   out  ADDR_W  latched address to L2
// l2_wdata  out  LINE_W  latched write data to L2
// l2_rdata  in   LINE_W  line from L2
// l2_resp   in   1       L2 completion, one cycle
// i_grants  out  CNT_W   saturating count of completed I transactions
// d_grants  out  CNT_W   saturating count of completed D transactions
//
// BEHAVIOUR
// - Reset:
//   - state=IDLE; last_grant=I, so D wins the first tie.
//   - l2_read, l2_write, i_resp and d_resp are 0; l2_addr and l2_wdata are 0; counters are 0.
//   - i_rdata and d_rdata are driven from l2_rdata and are don't-care.
//   - Reset mid-transaction abandons it: no resp pulse; L2 is expected to be reset in the same cycle.
// - FSM states: IDLE, SERVE_I, SERVE_D.
// - IDLE, arbitration on each cycle:
//   - i_req = i_read; d_req = d_read | d_write.
//   - Only one requesting: grant it.
//   - Both requesting: grant the one NOT equal to last_grant.
//   - Neither requesting: stay in IDLE.
// - On grant (IDLE -> SERVE_x, registered):
//   - Capture the winner's addr into l2_addr. For D, also capture d_wdata into l2_wdata.
//   - Set l2_read / l2_write from the winner. I always reads.
//   - If d_read and d_write are both high, it is a write: l2_write=1, l2_read=0.
//   - Set last_grant to the winner.
//   - l2_read/l2_write are asserted the cycle after the request is first seen in IDLE.
// - SERVE_x:
//   - l2_addr, l2_wdata, l2_read and l2_write stay stable until l2_resp.
//   - Requester inputs are ignored while in SERVE_x; changes have no effect.
//   - On l2_resp=1:
//     - x_resp=1 in the same cycle (combinational).
//     - x_rdata=l2_rdata in the same cycle.
//     - l2_read and l2_write drop next cycle.
//     - x_grants increments, saturating at all-ones.
//     - Next state is IDLE.
// - The non-granted resp is never asserted. i_resp and d_resp are never high together.
// - Turnaround:
//   - Exactly one IDLE cycle between transactions. No back-to-back grant in the resp cycle.
//   - A requester that deasserts in the cycle after its resp is not re-granted.
// - Fairness: under continuous requests from both sides, grants strictly alternate, so the worst-case wait is one transaction.
// - l2_resp arriving in IDLE is ignored: no resp pulse, no counter change.
//
// TESTING
// 1. Reset, then i_read=1, i_addr=0x0000_1040:
//    l2_read=1 and l2_addr=0x1040 the next cycle; L2 resp with data 0xA5..A5 -> i_resp=1, i_rdata=0xA5..A5, i_grants=1.
// 2. i_read and d_read asserted in the same cycle after reset:
//    D is served first; I is served after one IDLE cycle; i_grants=1 and d_grants=1.
// 3. Both requesters held high for 6 transactions:
//    grant order D,I,D,I,D,I; each side gets 3 grants.
// 4. D write-back addr=0x2000, wdata=0x1234..; change d_wdata and i_addr while in SERVE_D:
//    l2_write=1 with the latched 0x2000/0x1234.. until resp; d_resp pulses once.
// 5. Assert rst while in SERVE_I, before l2_resp:
//    next cycle state=IDLE, all outputs 0, no i_resp, counters 0.
// 6. d_read and d_write both high, then preload d_grants near max:
//    l2_write=1, l2_read=0; d_grants saturates at 0xFFFF and does not wrap.

Source files
------------

// File: rtl/l2_arbiter.sv
// l2_arbiter: round-robin share of the single L2 port between the L1 I-cache and D-cache miss paths.
// Latency: l2_read/l2_write assert one cycle after a request is seen in IDLE; x_resp/x_rdata are combinational with l2_resp.
// Backpressure: the loser holds its request; one IDLE cycle separates transactions, so continuous requesters alternate.
// Ports: clk/rst (sync, active-high); i_* and d_* requester sides; l2_* cache port; i_grants/d_grants saturating completion counts.
module l2_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp,
    output logic [CNT_W-1:0]  i_grants,
    output logic [CNT_W-1:0]  d_grants
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    // last_grant encoding: 0 = I, 1 = D
    localparam logic LG_I = 1'b0;
    localparam logic LG_D = 1'b1;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]  l2_addr_q, l2_addr_d;
    logic [LINE_W-1:0]  l2_wdata_q, l2_wdata_d;
    logic               l2_read_q, l2_read_d;
    logic               l2_write_q, l2_write_d;
    logic [CNT_W-1:0]   i_grants_q, i_grants_d;
    logic [CNT_W-1:0]   d_grants_q, d_grants_d;

    logic i_req, d_req, grant_i, grant_d;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // On a tie the side that did not win last time gets the port.
    assign grant_d = d_req & (~i_req | (last_grant_q == LG_I));
    assign grant_i = i_req & ~grant_d;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        l2_addr_d    = l2_addr_q;
        l2_wdata_d   = l2_wdata_q;
        l2_read_d    = l2_read_q;
        l2_write_d   = l2_write_q;
        i_grants_d   = i_grants_q;
        d_grants_d   = d_grants_q;

        case (state_q)
            IDLE: begin
                // l2_resp here has no owner and is dropped.
                if (grant_d) begin
                    state_d      = SERVE_D;
                    last_grant_d = LG_D;
                    l2_addr_d    = d_addr;
                    l2_wdata_d   = d_wdata;
                    // Write-back takes precedence when both strobes are high.
                    l2_write_d   = d_write;
                    l2_read_d    = d_read & ~d_write;
                end else if (grant_i) begin
                    state_d      = SERVE_I;
                    last_grant_d = LG_I;
                    l2_addr_d    = i_addr;
                    l2_read_d    = 1'b1;
                    l2_write_d   = 1'b0;
                end
            end
            SERVE_I: begin
                if (l2_resp) begin
                    state_d    = IDLE;
                    l2_read_d  = 1'b0;
                    l2_write_d = 1'b0;
                    if (i_grants_q != {CNT_W{1'b1}}) i_grants_d = i_grants_q + CNT_W'(1);
                end
            end
            SERVE_D: begin
                if (l2_resp) begin
                    state_d    = IDLE;
                    l2_read_d  = 1'b0;
                    l2_write_d = 1'b0;
                    if (d_grants_q != {CNT_W{1'b1}}) d_grants_d = d_grants_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                l2_read_d  = 1'b0;
                l2_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= LG_I;
            l2_addr_q    <= '0;
            l2_wdata_q   <= '0;
            l2_read_q    <= 1'b0;
            l2_write_q   <= 1'b0;
            i_grants_q   <= '0;
            d_grants_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            l2_addr_q    <= l2_addr_d;
            l2_wdata_q   <= l2_wdata_d;
            l2_read_q    <= l2_read_d;
            l2_write_q   <= l2_write_d;
            i_grants_q   <= i_grants_d;
            d_grants_q   <= d_grants_d;
        end
    end

    assign l2_addr  = l2_addr_q;
    assign l2_wdata = l2_wdata_q;
    assign l2_read  = l2_read_q;
    assign l2_write = l2_write_q;
    assign i_grants = i_grants_q;
    assign d_grants = d_grants_q;

    // Only the owner of the port ever sees the completion.
    assign i_resp  = (state_q == SERVE_I) & l2_resp;
    assign d_resp  = (state_q == SERVE_D) & l2_resp;
    assign i_rdata = l2_rdata;
    assign d_rdata = l2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
module tb_l2_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam int CNT_W  = 16;
    localparam int SAT_W  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read, d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              l2_read, l2_write;
    logic [ADDR_W-1:0] l2_addr;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_resp;
    logic [CNT_W-1:0]  i_grants, d_grants;

    // Second instance with narrow counters so saturation is reachable quickly.
    logic [LINE_W-1:0] s_i_rdata, s_d_rdata, s_l2_wdata;
    logic              s_i_resp, s_d_resp, s_l2_read, s_l2_write;
    logic [ADDR_W-1:0] s_l2_addr;
    logic [SAT_W-1:0]  s_i_grants, s_d_grants;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
        .l2_rdata(l2_rdata), .l2_resp(l2_resp),
        .i_grants(i_grants), .d_grants(d_grants)
    );

    l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(s_i_rdata), .i_resp(s_i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(s_d_rdata), .d_resp(s_d_resp),
        .l2_read(s_l2_read), .l2_write(s_l2_write), .l2_addr(s_l2_addr), .l2_wdata(s_l2_wdata),
        .l2_rdata(l2_rdata), .l2_resp(l2_resp),
        .i_grants(s_i_grants), .d_grants(s_d_grants)
    );

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [LINE_W-1:0] wd_a, wd_b, rd_a;
    logic              exp_d;
    int                exp_sat;

    initial begin
        rst = 1'b1; i_read = 0; i_addr = '0; d_read = 0; d_write = 0;
        d_addr = '0; d_wdata = '0; l2_rdata = '0; l2_resp = 0;
        wd_a = {8{32'h1234_5678}};
        wd_b = ~wd_a;
        rd_a = {32{8'hA5}};

        // ---- Test 1: reset state, single I read ----
        tick(); tick();
        chk("rst_l2_read",  LINE_W'(l2_read),  '0);
        chk("rst_l2_write", LINE_W'(l2_write), '0);
        chk("rst_l2_addr",  LINE_W'(l2_addr),  '0);
        chk("rst_l2_wdata", l2_wdata,          '0);
        chk("rst_i_grants", LINE_W'(i_grants), '0);
        chk("rst_d_grants", LINE_W'(d_grants), '0);
        chk("rst_i_resp",   LINE_W'(i_resp),   '0);
        chk("rst_d_resp",   LINE_W'(d_resp),   '0);
        rst = 0;
        i_read = 1; i_addr = 32'h0000_1040;
        chk("t1_idle_no_read", LINE_W'(l2_read), '0);
        tick();
        chk("t1_l2_read", LINE_W'(l2_read), 1);
        chk("t1_l2_addr", LINE_W'(l2_addr), 32'h1040);
        chk("t1_l2_write", LINE_W'(l2_write), '0);
        l2_rdata = rd_a; l2_resp = 1; #1;
        chk("t1_i_resp", LINE_W'(i_resp), 1);
        chk("t1_d_resp", LINE_W'(d_resp), 0);
        chk("t1_i_rdata", i_rdata, rd_a);
        tick();
        i_read = 0; l2_resp = 0;
        chk("t1_read_drop", LINE_W'(l2_read), 0);
        chk("t1_i_grants", LINE_W'(i_grants), 1);
        tick();
        chk("t1_no_regrant", LINE_W'(l2_read), 0);

        // ---- Test 2: simultaneous I and D after reset, D first ----
        rst = 1; tick(); rst = 0;
        i_read = 1; i_addr = 32'h0000_0100; d_read = 1; d_addr = 32'h0000_0200;
        tick();
        chk("t2_first_addr", LINE_W'(l2_addr), 32'h200);
        chk("t2_first_read", LINE_W'(l2_read), 1);
        l2_resp = 1; #1;
        chk("t2_d_resp", LINE_W'(d_resp), 1);
        chk("t2_i_resp_excl", LINE_W'(i_resp), 0);
        tick();
        l2_resp = 0; d_read = 0;
        chk("t2_turnaround", LINE_W'(l2_read), 0);
        tick();
        chk("t2_second_addr", LINE_W'(l2_addr), 32'h100);
        chk("t2_second_read", LINE_W'(l2_read), 1);
        l2_resp = 1; #1;
        chk("t2_i_resp", LINE_W'(i_resp), 1);
        chk("t2_d_resp_excl", LINE_W'(d_resp), 0);
        tick();
        l2_resp = 0; i_read = 0;
        chk("t2_i_grants", LINE_W'(i_grants), 1);
        chk("t2_d_grants", LINE_W'(d_grants), 1);

        // ---- Test 3: both held high for 6 transactions, strict alternation ----
        rst = 1; tick(); rst = 0;
        i_read = 1; d_read = 1;
        for (int k = 0; k < 6; k++) begin
            tick();
            exp_d = (k % 2 == 0);
            chk("t3_order_addr", LINE_W'(l2_addr), exp_d ? 32'h200 : 32'h100);
            l2_resp = 1; #1;
            chk("t3_i_resp", LINE_W'(i_resp), LINE_W'(!exp_d));
            chk("t3_d_resp", LINE_W'(d_resp), LINE_W'(exp_d));
            tick();
            l2_resp = 0;
            chk("t3_idle_gap", LINE_W'(l2_read), 0);
        end
        i_read = 0; d_read = 0;
        chk("t3_i_grants", LINE_W'(i_grants), 3);
        chk("t3_d_grants", LINE_W'(d_grants), 3);

        // ---- Test 4: D write-back with inputs changing mid-serve ----
        tick();
        d_write = 1; d_addr = 32'h0000_2000; d_wdata = wd_a;
        tick();
        chk("t4_l2_write", LINE_W'(l2_write), 1);
        chk("t4_l2_read", LINE_W'(l2_read), 0);
        chk("t4_l2_addr", LINE_W'(l2_addr), 32'h2000);
        chk("t4_l2_wdata", l2_wdata, wd_a);
        d_wdata = wd_b; d_addr = 32'h0000_3000; i_addr = 32'h0000_4000; i_read = 1; d_write = 0;
        tick(); tick();
        chk("t4_hold_write", LINE_W'(l2_write), 1);
        chk("t4_hold_addr", LINE_W'(l2_addr), 32'h2000);
        chk("t4_hold_wdata", l2_wdata, wd_a);
        chk("t4_no_resp_yet", LINE_W'(d_resp), 0);
        l2_resp = 1; #1;
        chk("t4_d_resp", LINE_W'(d_resp), 1);
        chk("t4_i_resp", LINE_W'(i_resp), 0);
        i_read = 0;
        tick();
        // l2_resp still high while IDLE: must be ignored
        chk("t4_idle_d_resp", LINE_W'(d_resp), 0);
        chk("t4_idle_i_resp", LINE_W'(i_resp), 0);
        chk("t4_write_drop", LINE_W'(l2_write), 0);
        tick();
        l2_resp = 0;
        chk("t4_d_grants", LINE_W'(d_grants), 4);
        chk("t4_i_grants", LINE_W'(i_grants), 3);

        // ---- Test 5: reset mid SERVE_I ----
        i_read = 1; i_addr = 32'h0000_1040;
        tick();
        chk("t5_serving", LINE_W'(l2_read), 1);
        rst = 1;
        tick();
        l2_resp = 1; #1;
        chk("t5_l2_read", LINE_W'(l2_read), 0);
        chk("t5_l2_write", LINE_W'(l2_write), 0);
        chk("t5_l2_addr", LINE_W'(l2_addr), 0);
        chk("t5_l2_wdata", l2_wdata, '0);
        chk("t5_i_resp", LINE_W'(i_resp), 0);
        chk("t5_i_grants", LINE_W'(i_grants), 0);
        chk("t5_d_grants", LINE_W'(d_grants), 0);
        rst = 0; i_read = 0; l2_resp = 0;
        tick();
        chk("t5_idle_after", LINE_W'(l2_read), 0);

        // ---- Test 6: read+write both high is a write; counter saturation ----
        d_read = 1; d_write = 1; d_addr = 32'h0000_5000;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk("t6_l2_write", LINE_W'(l2_write), 1);
            chk("t6_l2_read", LINE_W'(l2_read), 0);
            l2_resp = 1; #1;
            chk("t6_d_resp", LINE_W'(d_resp), 1);
            tick();
            l2_resp = 0;
            exp_sat = (k > 7) ? 7 : k;
            chk("t6_d_grants", LINE_W'(d_grants), LINE_W'(k));
            chk("t6_sat_d_grants", LINE_W'(s_d_grants), LINE_W'(exp_sat));
        end
        d_read = 0; d_write = 0;
        tick();
        chk("t6_sat_i_grants", LINE_W'(s_i_grants), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
